// File: rtl/dir_pkg.sv
// Direction codes and helpers shared by the joystick input path.
// Codes: 00 up, 01 down, 10 left, 11 right; opposite = code ^ 01.
package dir_pkg;

   localparam int DIR_W = 2;

   localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
   localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b01;
   localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
   localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;

   function automatic logic [DIR_W-1:0] dir_opposite(
      input logic [DIR_W-1:0] i_d
   );
      return i_d ^ 2'b01;
   endfunction

endpackage

// File: rtl/btn_sync_db.sv
// One button channel: 2-flop synchroniser, debounce, stable level, press pulse.
// Ports: clk, reset (sync, active-high), i_btn_n (raw, low = pressed),
//        o_state (debounced, 1 = pressed), o_down (1-cycle pulse on press).
module btn_sync_db
   import dir_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn_n,
   output logic o_state,
   output logic o_down
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic          r_down;
   logic [CW-1:0] r_cnt;

   logic w_level;
   logic w_diff;
   logic w_done;

   assign w_level = ~r_sync2;
   assign w_diff  = w_level != r_stable;
   assign w_done  = w_diff && (r_cnt == C_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b0;
         r_down   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
         // pulse only on the rising edge of the stable level
         r_down  <= w_done && w_level;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_done) begin
            r_stable <= w_level;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_state = r_stable;
   assign o_down  = r_down;

endmodule

// File: rtl/dir_input_queue.sv
// Debounced buttons -> filtered direction commands -> FIFO, one pop per tick.
// Ports: clk, reset, btn_n_i, tick_i; btn_state_o, btn_down_o, dir_o,
//        dir_upd_o, q_count_o, overflow_o.
// Macro DIR_REVERSE_FILTER_EN: also drop 180-degree reversals.
module dir_input_queue
   import dir_pkg::*;
#(
   parameter int               N_BTN           = 4,
   parameter int               DEBOUNCE_CYCLES = 250000,
   parameter int               DEPTH           = 4,
   parameter logic [DIR_W-1:0] INIT_DIR        = 2'b11
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_BTN-1:0]         btn_n_i,
   input  logic                     tick_i,
   output logic [N_BTN-1:0]         btn_state_o,
   output logic [N_BTN-1:0]         btn_down_o,
   output logic [DIR_W-1:0]         dir_o,
   output logic                     dir_upd_o,
   output logic [$clog2(DEPTH):0]   q_count_o,
   output logic                     overflow_o
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      btn_sync_db #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk     (clk),
         .reset   (reset),
         .i_btn_n (btn_n_i[g]),
         .o_state (btn_state_o[g]),
         .o_down  (btn_down_o[g])
      );
   end

   logic [DIR_W-1:0] r_fifo [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CNTW-1:0]  r_count;
   logic [DIR_W-1:0] r_dir;
   logic             r_dir_upd;
   logic             r_ovf;

   logic             w_cand_vld;
   logic [DIR_W-1:0] w_cand;
   logic [DIR_W-1:0] w_ref;
   logic             w_rev;
   logic             w_req;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop_full;

   // scan downward so the lowest set index is the last one written
   always_comb begin
      w_cand = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (btn_down_o[i]) w_cand = DIR_W'(i % 4);
      end
   end

   assign w_cand_vld = |btn_down_o;
   assign w_ref      = (r_count != '0) ? r_fifo[r_wr_ptr - 1'b1] : r_dir;

`ifdef DIR_REVERSE_FILTER_EN
   assign w_rev = w_cand == dir_opposite(w_ref);
`else
   assign w_rev = 1'b0;
`endif

   assign w_req       = w_cand_vld && (w_cand != w_ref) && !w_rev;
   assign w_full      = r_count == CNTW'(DEPTH);
   assign w_pop       = tick_i && (r_count != '0);
   // a pop in the same cycle frees the slot a full FIFO needs
   assign w_push      = w_req && (!w_full || w_pop);
   assign w_drop_full = w_req && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_cand;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_dir     <= INIT_DIR;
         r_dir_upd <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_dir_upd <= 1'b0;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_dir     <= r_fifo[r_rd_ptr];
            r_dir_upd <= r_fifo[r_rd_ptr] != r_dir;
         end
         if (w_push && !w_pop) r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
         if (w_drop_full) r_ovf <= 1'b1;
      end
   end

   assign dir_o      = r_dir;
   assign dir_upd_o  = r_dir_upd;
   assign q_count_o  = r_count;
   assign overflow_o = r_ovf;

endmodule

// File: doc/dir_input_queue.md
Name: dir_input_queue

Overview:
- Parametrised successor to the top-level joystick-button-to-direction logic in the snake game.
- Debounces N raw active-low buttons and converts presses into 2-bit direction commands.
- Filters duplicate commands and, optionally, reversals, then buffers them in a small FIFO.
- Releases one command per game update tick, so fast multi-key input between ticks is never lost or overwritten.
- Sits between the Arduino joystick pins and game_logic; runs on the 25 MHz vga_clk domain.

Parameters:
- N_BTN, 4, number of button channels; channel i maps to direction code i mod 4.
- DEBOUNCE_CYCLES, 250000, cycles a synchronised level must stay stable before it is accepted (10 ms at 25 MHz); minimum 2.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- INIT_DIR, 2'b11, direction driven on dir_o after reset.

Ports:
- clk  in  1  single clock (vga_clk, 25 MHz).
- reset  in  1  synchronous, active-high.
- btn_n_i  in  N_BTN  raw asynchronous buttons, low = pressed.
- tick_i  in  1  one-cycle game update strobe.
- btn_state_o  out  N_BTN  debounced level, 1 = pressed.
- btn_down_o  out  N_BTN  one-cycle pulse on debounced press.
- dir_o  out  2  current committed direction: 00 up, 01 down, 10 left, 11 right.
- dir_upd_o  out  1  one-cycle pulse when dir_o changes value from a pop.
- q_count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow_o  out  1  sticky; set when a command is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, active-high): sync FFs = 1; stable levels = released; debounce counters = 0; FIFO empty; dir_o = INIT_DIR. btn_state_o, btn_down_o, dir_upd_o, q_count_o and overflow_o all = 0.
- Synchronisation: two-flop synchroniser per channel.
- Debounce:
  - If the synchronised level differs from the stable level, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level flips and the counter clears.
  - Latency from a raw edge held steady to the btn_state_o change: 2 + DEBOUNCE_CYCLES cycles.
- btn_down_o[i]: registered pulse in the same cycle btn_state_o[i] rises. Releases produce no command.
- Candidate selection: among the btn_down_o bits set in a cycle, the lowest index wins; the others are discarded.
- Reference direction for filtering: the last FIFO entry if the FIFO is non-empty, else dir_o.
- Push filtering, applied in the cycle after btn_down_o:
  - A candidate equal to the reference is dropped.
  - With DIR_REVERSE_FILTER_EN defined, a candidate equal to reference ^ 2'b01 is dropped.
  - Otherwise the candidate is pushed; q_count_o increments in that same cycle.
- Pop: tick_i high with the FIFO non-empty pops the head into dir_o on the next edge. dir_upd_o pulses in that cycle if the value differs from the old dir_o.
- tick_i with the FIFO empty: no change, no pulse.
- Push and pop in the same cycle:
  - Both are performed; occupancy is unchanged.
  - If the FIFO is full, the push is still accepted because a slot frees.
  - If the FIFO is empty, only the push occurs; no bypass, so the new entry pops on a later tick.
- Push while full with no pop: the command is dropped and overflow_o is set. overflow_o clears only on reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; the count is kept separately.
- Reset asserted mid-debounce or mid-queue discards all state; the first cycle after reset behaves as a cold start.

Optional Feature:
- Macro: DIR_REVERSE_FILTER_EN.
- Defined: 180-degree reversals relative to the reference direction are dropped (a snake cannot fold onto itself).
- Undefined: reversals are pushed like any other non-duplicate command. Duplicate filtering is unaffected.

Decomposition:
- Package dir_pkg:
  - direction code localparams DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT;
  - function dir_opposite(d) = d ^ 2'b01;
  - direction width constant DIR_W = 2.
- Sub-module btn_sync_db: one channel containing the synchroniser, debounce counter, stable level and down pulse. It is instantiated N_BTN times via generate.
- The FIFO and filtering stay inline in dir_input_queue.

Test Plan (DEBOUNCE_CYCLES=4, DEPTH=4, INIT_DIR=11):
- Bounce rejection: btn_n_i[0] low 3 cycles, high, then low 10 cycles.
  - No pulse on the first glitch.
  - btn_down_o[0] pulses exactly 6 cycles after the final low edge.
  - q_count_o goes to 1 the next cycle.
- Ordered queue: press 0 (up), then 2 (left), then 1 (down) between ticks, then 3 ticks.
  - dir_o goes 11→00→10→01, with dir_upd_o pulsing on each tick.
- Duplicate and reversal: with dir_o = 11, press 3 then press 2.
  - With DIR_REVERSE_FILTER_EN, both are dropped and q_count_o stays 0.
  - Without it, only 3 is dropped and 10 is queued.
- Overflow: alternate presses 0,2,0,2,0 with no tick.
  - q_count_o saturates at 4; overflow_o = 1 after the 5th press.
  - A tick in the same cycle as a 5th push keeps q_count_o at 4 with overflow_o still 0.
- Simultaneous presses: buttons 1 and 3 debounce in the same cycle.
  - Only code 01 is queued (lowest index wins).
- Reset mid-operation: FIFO holds 2 entries and a debounce is in progress; assert reset for 1 cycle.
  - Next cycle: q_count_o = 0, dir_o = 11, overflow_o = 0, no btn_down_o pulses until a full debounce period elapses.
